ws2812_drive: RTL and testbench

//   Serial driver for the 8x8 WS2812 LED matrix of the snake display. Walks the frame

---
 rtl/ws2812_drive.sv | 148 ++++++++++++++
 tb/tb_ws2812_drive.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ws2812_drive.sv
// rtl/ws2812_drive.sv - WS2812 serial driver for the 8x8 LED matrix
//
// Purpose: walks the frame pixel by pixel and bit by bit, presents the current
//   (cnt_pixel, cnt_bit) to the colour lookup, takes back its combinational bit and
//   encodes it as a WS2812 high/low pulse. Every frame ends with the latch low time.
// Ports:
//   sys_clk     in   system clock
//   sys_rst_n   in   asynchronous active-low reset
//   start       in   frame request, honoured only in IDLE
//   bit_in      in   colour bit for (cnt_pixel, cnt_bit), combinational from lookup
//   cnt_bit     out  bit index within pixel, 0 = MSB (G[7])
//   cnt_pixel   out  pixel index within frame
//   dout        out  WS2812 serial data line
//   busy        out  high while sending or latching
//   frame_done  out  one-cycle pulse at the end of the latch time
module ws2812_drive #(
   parameter int PIXEL_NUM    = 64,
   parameter int BIT_NUM      = 24,
   parameter int T_BIT        = 60,
   parameter int T0H          = 18,
   parameter int T1H          = 36,
   parameter int RST_CYC      = 15000,
   parameter bit AUTO_REFRESH = 1'b0
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       start,
   input  logic       bit_in,
   output logic [4:0] cnt_bit,
   output logic [6:0] cnt_pixel,
   output logic       dout,
   output logic       busy,
   output logic       frame_done
);

   localparam int CYC_W = (T_BIT > 1) ? $clog2(T_BIT) : 1;
   localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [CYC_W-1:0] cnt_cyc;
   logic [RST_W-1:0] cnt_rst;

   logic cyc_end;
   logic bit_end;
   logic pix_end;
   logic rst_end;
   logic dout_next;

   // Terminal-count decodes shared by the FSM and the counters.
   assign cyc_end = (cnt_cyc == CYC_W'(T_BIT - 1));
   assign bit_end = (cnt_bit == 5'(BIT_NUM - 1));
   assign pix_end = (cnt_pixel == 7'(PIXEL_NUM - 1));
   assign rst_end = (state == LATCH) && (cnt_rst == RST_W'(RST_CYC - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      dout_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SEND;
            end
         end
         SEND: begin
            // High time is chosen by the bit currently presented by the lookup.
            dout_next = (32'(cnt_cyc) < (bit_in ? T1H : T0H));
            if (cyc_end && bit_end && pix_end) begin
               state_next = LATCH;
            end
         end
         LATCH: begin
            if (rst_end) begin
               state_next = AUTO_REFRESH ? SEND : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Slot, bit and pixel counters. Outside SEND they sit at zero so a new frame
   // always starts at pixel 0, bit 0, cycle 0 without extra setup.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_cyc   <= '0;
         cnt_bit   <= '0;
         cnt_pixel <= '0;
      end else if (state == SEND) begin
         if (cyc_end) begin
            cnt_cyc <= '0;
            if (bit_end) begin
               cnt_bit   <= '0;
               cnt_pixel <= pix_end ? 7'd0 : cnt_pixel + 7'd1;
            end else begin
               cnt_bit <= cnt_bit + 5'd1;
            end
         end else begin
            cnt_cyc <= cnt_cyc + CYC_W'(1);
         end
      end else begin
         cnt_cyc   <= '0;
         cnt_bit   <= '0;
         cnt_pixel <= '0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_rst <= '0;
      end else if (state == LATCH && !rst_end) begin
         cnt_rst <= cnt_rst + RST_W'(1);
      end else begin
         cnt_rst <= '0;
      end
   end

   // Registered outputs: dout trails the counters by one cycle for every bit;
   // busy follows the next state so it lines up with the state register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dout       <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         dout       <= dout_next;
         busy       <= (state_next != IDLE);
         frame_done <= rst_end;
      end
   end

endmodule

// File: tb/tb_ws2812_drive.sv
// tb/tb_ws2812_drive.sv - self-checking bench for ws2812_drive
module tb_ws2812_drive;

   localparam int PIX  = 6;
   localparam int BITS = 24;
   localparam int TB   = 10;
   localparam int T0   = 3;
   localparam int T1   = 6;
   localparam int RST  = 50;
   localparam int NT   = PIX * BITS * TB;
   localparam int L    = NT + RST;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic start_ar = 1'b0;
   logic bit_in;
   logic bit_in_ar;
   logic [4:0] cnt_bit, cnt_bit_ar;
   logic [6:0] cnt_pixel, cnt_pixel_ar;
   logic dout, dout_ar, busy, busy_ar, frame_done, frame_done_ar;

   logic [23:0] colour [PIX];

   int n_assert = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ws2812_drive #(.PIXEL_NUM(PIX), .BIT_NUM(BITS), .T_BIT(TB), .T0H(T0), .T1H(T1),
                  .RST_CYC(RST), .AUTO_REFRESH(1'b0)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .bit_in(bit_in),
      .cnt_bit(cnt_bit), .cnt_pixel(cnt_pixel), .dout(dout), .busy(busy),
      .frame_done(frame_done));

   ws2812_drive #(.PIXEL_NUM(PIX), .BIT_NUM(BITS), .T_BIT(TB), .T0H(T0), .T1H(T1),
                  .RST_CYC(RST), .AUTO_REFRESH(1'b1)) dut_ar (
      .sys_clk(clk), .sys_rst_n(rst_n), .start(start_ar), .bit_in(bit_in_ar),
      .cnt_bit(cnt_bit_ar), .cnt_pixel(cnt_pixel_ar), .dout(dout_ar), .busy(busy_ar),
      .frame_done(frame_done_ar));

   // Colour lookup model: GRB word per pixel, cnt_bit 0 selects the MSB.
   always_comb begin
      bit_in = 1'b0;
      if (int'(cnt_pixel) < PIX && int'(cnt_bit) < BITS)
         bit_in = colour[cnt_pixel][BITS-1-int'(cnt_bit)];
   end

   always_comb begin
      bit_in_ar = 1'b0;
      if (int'(cnt_pixel_ar) < PIX && int'(cnt_bit_ar) < BITS)
         bit_in_ar = colour[cnt_pixel_ar][BITS-1-int'(cnt_bit_ar)];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one frame on dut, checking the whole waveform sample by sample against
   // the colour table; optionally pokes start while busy or aborts with a reset.
   task automatic run_frame(input int abort_k, input bit extra_starts);
      int hi;
      int slot;
      int nc;
      logic b;
      logic exp_d;
      logic [23:0] dec [PIX];
      hi = 0;
      for (int p = 0; p < PIX; p++) dec[p] = '0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("busy_on", 32'(busy), 32'd1);
      for (int k = 0; k < L; k++) begin
         @(negedge clk);
         if (extra_starts) start = (k == 3 || k == NT + 10);
         slot = k / TB;
         b = 1'b0;
         if (k < NT) b = colour[slot / BITS][BITS - 1 - (slot % BITS)];
         exp_d = (k < NT) && ((k % TB) < (b ? T1 : T0));
         check("dout", 32'(dout), 32'(exp_d));
         check("busy", 32'(busy), (k < L - 1) ? 32'd1 : 32'd0);
         check("frame_done", 32'(frame_done), (k < L - 1) ? 32'd0 : 32'd1);
         nc = k + 1;
         check("cnt_pixel", 32'(cnt_pixel), (nc < NT) ? 32'((nc / TB) / BITS) : 32'd0);
         check("cnt_bit", 32'(cnt_bit), (nc < NT) ? 32'((nc / TB) % BITS) : 32'd0);
         if (k < NT) begin
            hi += int'(dout);
            if (k % TB == TB - 1) begin
               dec[slot / BITS] = {dec[slot / BITS][22:0], (hi * 2 > T0 + T1)};
               hi = 0;
            end
         end
         if (k == abort_k) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_dout", 32'(dout), 32'd0);
            check("rst_cnt_pixel", 32'(cnt_pixel), 32'd0);
            check("rst_cnt_bit", 32'(cnt_bit), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            @(negedge clk) rst_n = 1'b1;
            return;
         end
      end
      start = 1'b0;
      @(negedge clk);
      check("frame_done_pulse", 32'(frame_done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      for (int p = 0; p < PIX; p++) check("decoded_pixel", 32'(dec[p]), 32'(colour[p]));
   endtask

   initial begin
      for (int p = 0; p < PIX; p++) colour[p] = '0;
      #1;
      check("reset_dout", 32'(dout), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_frame_done", 32'(frame_done), 32'd0);
      check("reset_cnt_bit", 32'(cnt_bit), 32'd0);
      check("reset_cnt_pixel", 32'(cnt_pixel), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // All zero bits.
      run_frame(-1, 1'b0);

      // All one bits.
      for (int p = 0; p < PIX; p++) colour[p] = 24'hFFFFFF;
      run_frame(-1, 1'b0);

      // Red at pixel 5 only: GRB 00FF00.
      for (int p = 0; p < PIX; p++) colour[p] = '0;
      colour[5] = 24'h00FF00;
      run_frame(-1, 1'b0);

      // Random colours with start pokes during SEND and LATCH.
      for (int p = 0; p < PIX; p++) colour[p] = 24'($urandom);
      run_frame(-1, 1'b1);

      // Reset in the middle of pixel 3, bit 12, then a full fresh frame.
      for (int p = 0; p < PIX; p++) colour[p] = 24'($urandom);
      run_frame((3 * BITS + 12) * TB + 2, 1'b0);
      @(negedge clk);
      run_frame(-1, 1'b0);

      // Continuous refresh: frame_done every L cycles with no idle gap.
      @(negedge clk) start_ar = 1'b1;
      @(negedge clk) start_ar = 1'b0;
      for (int c = 1; c <= 2 * L; c++) begin
         @(negedge clk);
         check("ar_frame_done", 32'(frame_done_ar), (c == L || c == 2 * L) ? 32'd1 : 32'd0);
         check("ar_busy", 32'(busy_ar), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
